dbg_sig_sel_flt: RTL and testbench

//  Debug probe front end; sits directly upstream of the high/low pulse-width counter.

---
 rtl/dbg_sig_sel_flt.sv | 135 +++++++++++++
 tb/tb_dbg_sig_sel_flt.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_sig_sel_flt.sv
// Debug probe front end: selects one raw probe, optionally inverts, synchronises and
// deglitches it, and reports filtered level, restart clear and edge count to the host.
module dbg_sig_sel_flt #(
    parameter int unsigned NUM_SIG    = 8,
    parameter int unsigned SEL_WH     = 3,
    parameter int unsigned WE_WIDTH   = 8,
    parameter int unsigned RE_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WE_WIDTH-1:0]   iWE_BIT,
    input  logic [RE_WIDTH-1:0]   iRE_BIT,
    input  logic [DATA_WIDTH-1:0] iDATA,
    output logic [DATA_WIDTH-1:0] oRD,
    input  logic [NUM_SIG-1:0]    iPROBE,
    output logic                  oSIG,
    output logic                  oCLR
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] THR_RST = 8'h03;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    logic [SEL_WH-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]  thr_q, thr_d;
    logic              en_q, en_d;
    logic              inv_q, inv_d;
    logic              pend_q, pend_d;
    logic              clr_q, clr_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sig_q, sig_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic              raw_sel;
    logic              cfg_wr;
    logic              unused_bits;

    assign cfg_wr      = |iWE_BIT[2:0];
    assign unused_bits = ^{iWE_BIT[WE_WIDTH-1:3], iRE_BIT[RE_WIDTH-1:4]};

    // Probe mux; an out-of-range select yields constant 0
    always_comb begin : probe_mux
        raw_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_SIG; i++) begin
            if (sel_q == SEL_WH'(i)) begin
                raw_sel = iPROBE[i];
            end
        end
    end

    always_comb begin : next_state
        sel_d   = sel_q;
        thr_d   = thr_q;
        en_d    = en_q;
        inv_d   = inv_q;
        pend_d  = cfg_wr;
        clr_d   = pend_q;
        sync1_d = sync1_q;
        sync2_d = sync2_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        ecnt_d  = ecnt_q;

        if (iWE_BIT[0]) sel_d = iDATA[SEL_WH-1:0];
        if (iWE_BIT[1]) thr_d = iDATA[CNT_W-1:0];
        if (iWE_BIT[2]) begin
            en_d  = iDATA[0];
            inv_d = iDATA[1];
        end

        // A config write restarts the whole datapath one cycle later, alongside oCLR
        if (pend_q || !en_q) begin
            sync1_d = 1'b0;
            sync2_d = 1'b0;
            sig_d   = 1'b0;
            cnt_d   = '0;
            if (pend_q) ecnt_d = '0;
        end else begin
            sync1_d = raw_sel ^ inv_q;
            sync2_d = sync1_q;
            if (sync2_q == sig_q) begin
                cnt_d = '0;
            end else if (cnt_q >= thr_q) begin
                sig_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if ((sig_d != sig_q) && (ecnt_q != CNT_MAX)) ecnt_d = ecnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin : regs
        if (RST) begin
            sel_q   <= '0;
            thr_q   <= THR_RST;
            en_q    <= 1'b1;
            inv_q   <= 1'b0;
            pend_q  <= 1'b0;
            clr_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sig_q   <= 1'b0;
            cnt_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            sel_q   <= sel_d;
            thr_q   <= thr_d;
            en_q    <= en_d;
            inv_q   <= inv_d;
            pend_q  <= pend_d;
            clr_q   <= clr_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // Host read: OR of every addressed field
    always_comb begin : read_mux
        oRD = '0;
        if (iRE_BIT[0]) oRD = oRD | DATA_WIDTH'(sel_q);
        if (iRE_BIT[1]) oRD = oRD | DATA_WIDTH'(thr_q);
        if (iRE_BIT[2]) oRD = oRD | DATA_WIDTH'({inv_q, en_q});
        if (iRE_BIT[3]) oRD = oRD | DATA_WIDTH'(ecnt_q);
    end

    assign oSIG = sig_q;
    assign oCLR = clr_q;

endmodule

// File: tb/tb_dbg_sig_sel_flt.sv
// Bench for dbg_sig_sel_flt: timed expectations are queued as stimulus is driven and
// compared on the falling edge of the cycle they target.
module tb_dbg_sig_sel_flt;

    localparam int unsigned NSIG = 6;
    localparam int K_SIG = 0;
    localparam int K_CLR = 1;
    localparam int K_RD  = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] iWE_BIT = '0;
    logic [7:0] iRE_BIT = '0;
    logic [7:0] iDATA = '0;
    logic [7:0] oRD;
    logic [NSIG-1:0] iPROBE = '0;
    logic       oSIG;
    logic       oCLR;

    typedef struct {
        int unsigned cyc;
        int          kind;
        logic [7:0]  val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int unsigned c;

    dbg_sig_sel_flt #(
        .NUM_SIG(NSIG), .SEL_WH(3), .WE_WIDTH(8), .RE_WIDTH(8), .DATA_WIDTH(8)
    ) dut (
        .CLK(CLK), .RST(RST), .iWE_BIT(iWE_BIT), .iRE_BIT(iRE_BIT), .iDATA(iDATA),
        .oRD(oRD), .iPROBE(iPROBE), .oSIG(oSIG), .oCLR(oCLR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard drain: everything due in this cycle
    always @(negedge CLK) begin
        logic [7:0] obs;
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_SIG:   obs = {7'd0, oSIG};
                    K_CLR:   obs = {7'd0, oCLR};
                    default: obs = oRD;
                endcase
                check(sb[i].tag, 32'(obs), 32'(sb[i].val));
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic expect_at(input int unsigned off, input int kind, input logic [7:0] v,
                             input string tag);
        exp_t e;
        e.cyc  = cyc + off;
        e.kind = kind;
        e.val  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [7:0] we, input logic [7:0] d, input bit cfg);
        iWE_BIT = we;
        iDATA   = d;
        expect_at(1, K_CLR, 8'd0, "clr_pre");
        expect_at(2, K_CLR, cfg ? 8'd1 : 8'd0, "clr_pulse");
        expect_at(3, K_CLR, 8'd0, "clr_post");
        step();
        iWE_BIT = '0;
        step();
        step();
    endtask

    task automatic rd(input logic [7:0] re, input logic [7:0] v, input string tag);
        iRE_BIT = re;
        expect_at(0, K_RD, v, tag);
        step();
        iRE_BIT = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and read-back
        idle(3);
        expect_at(0, K_SIG, 8'd0, "rst_sig");
        expect_at(0, K_CLR, 8'd0, "rst_clr");
        RST = 1'b0;
        rd(8'h01, 8'h00, "rst_sel");
        rd(8'h02, 8'h03, "rst_thr");
        rd(8'h04, 8'h01, "rst_ctrl");
        rd(8'h08, 8'h00, "rst_stat");
        rd(8'h00, 8'h00, "rd_none");

        // Selected probe rise appears T+2 cycles after capture; others ignored
        wr(8'h01, 8'h02, 1'b1);
        c = cyc;
        iPROBE[2] = 1'b1;
        for (int o = 1; o <= 5; o++) expect_at(o, K_SIG, 8'd0, "t1_sig_lo");
        for (int o = 6; o <= 10; o++) expect_at(o, K_SIG, 8'd1, "t1_sig_hi");
        for (int i = 0; i < 10; i++) begin
            iPROBE = iPROBE ^ 6'b111011;
            step();
        end
        rd(8'h08, 8'h01, "t1_stat");

        // Short pulse suppressed, T+1 pulse passes for its full width
        iPROBE = '0;
        wr(8'h01, 8'h02, 1'b1);
        iPROBE[2] = 1'b1;
        for (int o = 1; o <= 10; o++) expect_at(o, K_SIG, 8'd0, "t2_short");
        idle(3);
        iPROBE[2] = 1'b0;
        idle(9);
        iPROBE[2] = 1'b1;
        for (int o = 1; o <= 5; o++) expect_at(o, K_SIG, 8'd0, "t2_pre");
        for (int o = 6; o <= 9; o++) expect_at(o, K_SIG, 8'd1, "t2_high");
        for (int o = 10; o <= 11; o++) expect_at(o, K_SIG, 8'd0, "t2_post");
        idle(4);
        iPROBE[2] = 1'b0;
        idle(10);
        rd(8'h08, 8'h02, "t2_stat");

        // T=0 with inversion; edge count saturates
        wr(8'h02, 8'h00, 1'b1);
        wr(8'h04, 8'h03, 1'b1);
        expect_at(0, K_SIG, 8'd0, "t3_sig0");
        expect_at(1, K_SIG, 8'd0, "t3_sig1");
        expect_at(2, K_SIG, 8'd1, "t3_sig2");
        idle(3);
        rd(8'h04, 8'h03, "t3_ctrl");
        rd(8'h08, 8'h01, "t3_stat1");
        for (int i = 0; i < 300; i++) begin
            iPROBE[2] = ~iPROBE[2];
            step();
        end
        idle(5);
        rd(8'h08, 8'hFF, "t3_sat");
        for (int i = 0; i < 20; i++) begin
            iPROBE[2] = ~iPROBE[2];
            step();
        end
        idle(5);
        rd(8'h08, 8'hFF, "t3_hold");

        // Select write mid-filter restarts everything
        iPROBE = '0;
        wr(8'h04, 8'h01, 1'b1);
        wr(8'h02, 8'h03, 1'b1);
        iPROBE[3] = 1'b1;
        wr(8'h01, 8'h02, 1'b1);
        c = cyc;
        iPROBE[2] = 1'b1;
        for (int o = 1; o <= 6; o++) expect_at(o, K_SIG, 8'd0, "t4_mid");
        idle(4);
        wr(8'h01, 8'h03, 1'b1);
        for (int o = 0; o <= 4; o++) expect_at(o, K_SIG, 8'd0, "t4_restart");
        expect_at(5, K_SIG, 8'd1, "t4_rise");
        rd(8'h08, 8'h00, "t4_stat_clr");
        idle(6);
        rd(8'h08, 8'h01, "t4_stat1");

        // Out-of-range select yields constant 0
        iPROBE = '1;
        wr(8'h01, 8'h07, 1'b1);
        for (int o = 0; o <= 10; o++) expect_at(o, K_SIG, 8'd0, "t4_sel7");
        idle(11);
        rd(8'h01, 8'h07, "t4_sel7_rd");

        // Simultaneous writes, OR'd reads, ignored strobes
        iPROBE = '0;
        wr(8'h03, 8'h06, 1'b1);
        rd(8'h01, 8'h06, "mw_sel");
        rd(8'h02, 8'h06, "mw_thr");
        wr(8'h02, 8'h30, 1'b1);
        rd(8'h07, 8'h37, "rd_or");
        rd(8'h10, 8'h00, "rd_upper");
        wr(8'h08, 8'hFF, 1'b0);
        rd(8'h08, 8'h00, "stat_ro");
        wr(8'h10, 8'hFF, 1'b0);
        rd(8'h07, 8'h37, "we_upper");

        // Disable, then reset mid-count
        wr(8'h02, 8'h03, 1'b1);
        wr(8'h01, 8'h02, 1'b1);
        wr(8'h04, 8'h00, 1'b1);
        for (int o = 0; o <= 12; o++) expect_at(o, K_SIG, 8'd0, "t5_dis");
        for (int i = 0; i < 10; i++) begin
            iPROBE[2] = ~iPROBE[2];
            step();
        end
        idle(3);
        rd(8'h04, 8'h00, "t5_ctrl0");
        iPROBE = '0;
        wr(8'h04, 8'h01, 1'b1);
        iPROBE[2] = 1'b1;
        idle(4);
        RST = 1'b1;
        for (int o = 0; o <= 8; o++) begin
            expect_at(o, K_SIG, 8'd0, "t5_rst_sig");
            expect_at(o, K_CLR, 8'd0, "t5_rst_clr");
        end
        iPROBE = '0;
        idle(2);
        RST = 1'b0;
        idle(7);
        rd(8'h02, 8'h03, "t5_thr");
        rd(8'h04, 8'h01, "t5_ctrl");
        rd(8'h01, 8'h00, "t5_sel");
        rd(8'h08, 8'h00, "t5_stat");

        idle(2);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
